ddr_write_packer: RTL and testbench

//  Sits in the DDR controller (ui_clk) domain, directly downstream of the CDC

---
 rtl/ddr_write_packer.sv | 138 +++++++++++++
 tb/tb_ddr_write_packer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_write_packer.sv
// Packs {word, word-address} beats from the CDC FIFO into 8-word, 128-bit lines
// and issues each line as one MIG write command plus one single-beat write-data transfer.
//
// state    | meaning
// WAIT_CAL | waiting for MIG calibration; no beats accepted
// ACCUM    | collecting beats into the line buffer
// ISSUE    | command and write data presented; waiting for both handshakes
module ddr_write_packer #(
    parameter int FLUSH_TIMEOUT  = 64,
    parameter int APP_ADDR_WIDTH = 27
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      init_calib_complete,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [15:0]               s_axis_tdata,
    input  logic [23:0]               s_axis_taddr,
    input  logic                      flush_in,
    output logic [APP_ADDR_WIDTH-1:0] app_addr,
    output logic [2:0]                app_cmd,
    output logic                      app_en,
    input  logic                      app_rdy,
    output logic [127:0]              app_wdf_data,
    output logic [15:0]               app_wdf_mask,
    output logic                      app_wdf_wren,
    output logic                      app_wdf_end,
    input  logic                      app_wdf_rdy,
    output logic                      busy
);

    localparam int TW = (FLUSH_TIMEOUT < 2) ? 1 : $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(FLUSH_TIMEOUT);

    typedef enum logic [1:0] {
        WAIT_CAL = 2'd0,
        ACCUM    = 2'd1,
        ISSUE    = 2'd2
    } state_t;

    state_t        state;
    logic          occupied;
    logic [20:0]   cur_line;
    logic [TW-1:0] idle_left;

    logic [20:0]   beat_line;
    logic [2:0]    beat_lane;
    logic          line_match;
    logic          accept;
    logic          mismatch;
    logic          timeout_hit;
    logic          go_issue;
    logic          cmd_done;
    logic          data_done;
    logic [15:0]   mask_upd;
    logic [127:0]  data_upd;

    assign beat_line = s_axis_taddr[23:3];
    assign beat_lane = s_axis_taddr[2:0];

    // Buffer contents as they would look with the current beat merged in.
    always_comb begin
        mask_upd = app_wdf_mask;
        data_upd = app_wdf_data;
        mask_upd[{beat_lane, 1'b0} +: 2]    = 2'b00;
        data_upd[{beat_lane, 4'b0000} +: 16] = s_axis_tdata;
    end

    assign line_match    = (beat_line == cur_line);
    assign s_axis_tready = (state == ACCUM) && (!occupied || line_match);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign mismatch      = (state == ACCUM) && occupied && s_axis_tvalid && !line_match;

    // Down-counter reloads on every accepted beat; the terminal count is the
    // idle cycle that brings it to zero, so the flush lands FLUSH_TIMEOUT
    // cycles after the last accepted beat.
    assign timeout_hit = (FLUSH_TIMEOUT != 0) && occupied && !accept
                         && (idle_left <= TW'(1));

    assign go_issue  = (accept && (mask_upd == 16'h0000)) || mismatch || timeout_hit
                       || (flush_in && occupied);
    assign cmd_done  = !app_en || app_rdy;
    assign data_done = !app_wdf_wren || app_wdf_rdy;

    assign app_cmd     = 3'b000;
    assign app_wdf_end = app_wdf_wren;
    assign busy        = occupied || (state == ISSUE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WAIT_CAL;
            occupied     <= 1'b0;
            cur_line     <= '0;
            idle_left    <= TIMEOUT_LOAD;
            app_addr     <= '0;
            app_en       <= 1'b0;
            app_wdf_wren <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_mask <= 16'hFFFF;
        end else begin
            case (state)
                WAIT_CAL: begin
                    if (init_calib_complete) state <= ACCUM;
                end
                ACCUM: begin
                    if (accept) begin
                        app_wdf_data <= data_upd;
                        app_wdf_mask <= mask_upd;
                        idle_left    <= TIMEOUT_LOAD;
                        if (!occupied) begin
                            occupied <= 1'b1;
                            cur_line <= beat_line;
                            app_addr <= APP_ADDR_WIDTH'({beat_line, 3'b000});
                        end
                    end else if (occupied && idle_left != '0) begin
                        idle_left <= idle_left - TW'(1);
                    end
                    if (go_issue) begin
                        state        <= ISSUE;
                        app_en       <= 1'b1;
                        app_wdf_wren <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (app_rdy)     app_en       <= 1'b0;
                    if (app_wdf_rdy) app_wdf_wren <= 1'b0;
                    if (cmd_done && data_done) begin
                        app_wdf_mask <= 16'hFFFF;
                        occupied     <= 1'b0;
                        state        <= ACCUM;
                    end
                end
                default: state <= WAIT_CAL;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_write_packer.sv
// Directed bench for ddr_write_packer: line packing, mismatch stall, idle flush,
// MIG back-pressure, overwrite, explicit flush and reset behaviour.
module tb_ddr_write_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic         init_calib_complete;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [15:0]  s_axis_tdata;
    logic [23:0]  s_axis_taddr;
    logic         flush_in;
    logic [26:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic         app_wdf_rdy;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int cmd_count  = 0;
    int data_count = 0;

    ddr_write_packer #(.FLUSH_TIMEOUT(64), .APP_ADDR_WIDTH(27)) dut (
        .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_taddr(s_axis_taddr),
        .flush_in(flush_in),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_rdy(app_wdf_rdy), .busy(busy)
    );

    always #5 clk = ~clk;

    // Handshake counters: one command and one data beat per issued line.
    always @(posedge clk) begin
        if (app_en && app_rdy) cmd_count++;
        if (app_wdf_wren && app_wdf_rdy) data_count++;
    end

    // Called and returns at posedge+#1; returns just after the accepting edge.
    task automatic send_beat(input logic [15:0] d, input logic [23:0] a);
        bit ok;
        ok = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_taddr  = a;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = s_axis_tready;
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_beat_timeout addr=%0h accepted=%0b required=1", a, ok);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; init_calib_complete = 1'b0; flush_in = 1'b0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        s_axis_tvalid = 1'b1; s_axis_tdata = 16'hDEAD; s_axis_taddr = 24'h000010;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({app_en, app_wdf_wren, app_wdf_end, busy, s_axis_tready} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_ctrl got en/wren/end/busy/tready=%b required=00000",
                     {app_en, app_wdf_wren, app_wdf_end, busy, s_axis_tready});
        end
        checks++;
        if (app_addr !== 27'h0 || app_wdf_data !== 128'h0 || app_wdf_mask !== 16'hFFFF || app_cmd !== 3'b000) begin
            failures++;
            $display("FAIL reset_data got addr=%0h data=%0h mask=%0h cmd=%0h required addr=0 data=0 mask=ffff cmd=0",
                     app_addr, app_wdf_data, app_wdf_mask, app_cmd);
        end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (s_axis_tready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL wait_cal_tready got tready=%b busy=%b required 0 0", s_axis_tready, busy);
        end
        s_axis_tvalid = 1'b0;
        init_calib_complete = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (s_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL accum_tready got=%b required=1", s_axis_tready);
        end
    endtask

    task automatic test_full_line();
        logic [127:0] exp;
        int c0, d0;
        c0 = cmd_count; d0 = data_count;
        for (int i = 0; i < 8; i++) exp[16*i +: 16] = 16'(16'h1000 + i);
        for (int i = 0; i < 8; i++) send_beat(16'(16'h1000 + i), 24'(24'h000010 + i));
        checks++;
        if ({app_en, app_wdf_wren, app_wdf_end, busy} !== 4'b1111) begin
            failures++;
            $display("FAIL full_latency got en/wren/end/busy=%b required=1111",
                     {app_en, app_wdf_wren, app_wdf_end, busy});
        end
        checks++;
        if (app_addr !== 27'h10 || app_wdf_data !== exp || app_wdf_mask !== 16'h0000) begin
            failures++;
            $display("FAIL full_payload got addr=%0h data=%0h mask=%0h required addr=10 data=%0h mask=0",
                     app_addr, app_wdf_data, app_wdf_mask, exp);
        end
        @(posedge clk); #1;
        checks++;
        if (app_en !== 1'b0 || app_wdf_wren !== 1'b0 || app_wdf_mask !== 16'hFFFF || busy !== 1'b0) begin
            failures++;
            $display("FAIL full_done got en=%b wren=%b mask=%0h busy=%b required 0 0 ffff 0",
                     app_en, app_wdf_wren, app_wdf_mask, busy);
        end
        checks++;
        if (cmd_count - c0 != 1 || data_count - d0 != 1) begin
            failures++;
            $display("FAIL full_count got cmds=%0d datas=%0d required 1 1", cmd_count - c0, data_count - d0);
        end
    endtask

    task automatic test_mismatch();
        for (int i = 0; i < 3; i++) send_beat(16'(16'h2000 + i), 24'(24'h000010 + i));
        s_axis_tvalid = 1'b1; s_axis_tdata = 16'h5555; s_axis_taddr = 24'h000028;
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b0) begin
            failures++;
            $display("FAIL mismatch_stall got tready=%b required=0", s_axis_tready);
        end
        @(posedge clk); #1;
        checks++;
        if (app_en !== 1'b1 || app_addr !== 27'h10 || app_wdf_mask !== 16'hFFC0
            || app_wdf_data[47:0] !== 48'h2002_2001_2000) begin
            failures++;
            $display("FAIL mismatch_issue got en=%b addr=%0h mask=%0h data=%0h required 1 10 ffc0 200220012000",
                     app_en, app_addr, app_wdf_mask, app_wdf_data[47:0]);
        end
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b0) begin
            failures++;
            $display("FAIL mismatch_issue_tready got=%b required=0", s_axis_tready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL mismatch_resume got tready=%b required=1", s_axis_tready);
        end
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        checks++;
        if (app_addr !== 27'h28 || app_wdf_mask !== 16'hFFFC || app_wdf_data[15:0] !== 16'h5555 || app_en !== 1'b0) begin
            failures++;
            $display("FAIL mismatch_accepted got addr=%0h mask=%0h lane0=%0h en=%b required 28 fffc 5555 0",
                     app_addr, app_wdf_mask, app_wdf_data[15:0], app_en);
        end
        flush_in = 1'b1;
        @(posedge clk); #1;
        flush_in = 1'b0;
        checks++;
        if (app_en !== 1'b1 || app_addr !== 27'h28) begin
            failures++;
            $display("FAIL mismatch_flush got en=%b addr=%0h required 1 28", app_en, app_addr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        bit early;
        early = 1'b0;
        send_beat(16'h3333, 24'h000033);
        for (int i = 0; i < 63; i++) begin
            @(posedge clk); #1;
            if (app_en) early = 1'b1;
        end
        checks++;
        if (early) begin
            failures++;
            $display("FAIL timeout_early got app_en before cycle 64 required none");
        end
        @(posedge clk); #1;
        checks++;
        if (app_en !== 1'b1 || app_addr !== 27'h30 || app_wdf_mask !== 16'hFF3F || app_wdf_data[63:48] !== 16'h3333) begin
            failures++;
            $display("FAIL timeout_issue got en=%b addr=%0h mask=%0h lane3=%0h required 1 30 ff3f 3333",
                     app_en, app_addr, app_wdf_mask, app_wdf_data[63:48]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int en_cycles, wren_cycles, c0;
        bit tready_seen;
        en_cycles = 0; wren_cycles = 0; tready_seen = 1'b0;
        c0 = cmd_count;
        app_rdy = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(16'(16'h4000 + i), 24'(24'h000040 + i));
        for (int k = 1; k <= 6; k++) begin
            if (app_en) en_cycles++;
            if (app_wdf_wren) wren_cycles++;
            if (s_axis_tready) tready_seen = 1'b1;
            app_rdy = (k == 6);
            @(posedge clk); #1;
        end
        app_rdy = 1'b1;
        checks++;
        if (en_cycles != 6 || wren_cycles != 1) begin
            failures++;
            $display("FAIL bp_hold got en_cycles=%0d wren_cycles=%0d required 6 1", en_cycles, wren_cycles);
        end
        checks++;
        if (tready_seen) begin
            failures++;
            $display("FAIL bp_tready got tready high during issue required low");
        end
        checks++;
        if (app_en !== 1'b0 || busy !== 1'b0 || cmd_count - c0 != 1) begin
            failures++;
            $display("FAIL bp_done got en=%b busy=%b cmds=%0d required 0 0 1", app_en, busy, cmd_count - c0);
        end
    endtask

    task automatic test_overwrite_flush();
        bit spurious;
        int c0;
        spurious = 1'b0;
        send_beat(16'hAAAA, 24'h000054);
        send_beat(16'h5555, 24'h000054);
        checks++;
        if (app_en !== 1'b0 || app_wdf_mask !== 16'hFCFF) begin
            failures++;
            $display("FAIL overwrite_pending got en=%b mask=%0h required 0 fcff", app_en, app_wdf_mask);
        end
        flush_in = 1'b1;
        @(posedge clk); #1;
        flush_in = 1'b0;
        checks++;
        if (app_en !== 1'b1 || app_addr !== 27'h50 || app_wdf_mask !== 16'hFCFF || app_wdf_data[79:64] !== 16'h5555) begin
            failures++;
            $display("FAIL overwrite_issue got en=%b addr=%0h mask=%0h lane4=%0h required 1 50 fcff 5555",
                     app_en, app_addr, app_wdf_mask, app_wdf_data[79:64]);
        end
        @(posedge clk); #1;
        c0 = cmd_count;
        flush_in = 1'b1;
        @(posedge clk); #1;
        flush_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (app_en || busy) spurious = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (spurious || cmd_count != c0) begin
            failures++;
            $display("FAIL empty_flush got en_or_busy=%b cmds=%0d required 0 0", spurious, cmd_count - c0);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp;
        int c0;
        c0 = cmd_count;
        for (int i = 0; i < 8; i++) exp[16*i +: 16] = 16'(16'h8800 + i);
        for (int i = 0; i < 8; i++) send_beat(16'(16'h8000 + i), 24'(24'h000080 + i));
        for (int i = 0; i < 8; i++) send_beat(16'(16'h8800 + i), 24'(24'h000088 + i));
        checks++;
        if (app_en !== 1'b1 || app_addr !== 27'h88 || app_wdf_data !== exp || app_wdf_mask !== 16'h0000) begin
            failures++;
            $display("FAIL b2b_second got en=%b addr=%0h data=%0h mask=%0h required 1 88 %0h 0",
                     app_en, app_addr, app_wdf_data, app_wdf_mask, exp);
        end
        @(posedge clk); #1;
        checks++;
        if (cmd_count - c0 != 2) begin
            failures++;
            $display("FAIL b2b_count got cmds=%0d required 2", cmd_count - c0);
        end
    endtask

    task automatic test_reset_mid_issue();
        int c0;
        c0 = cmd_count;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(16'(16'h6000 + i), 24'(24'h000060 + i));
        @(posedge clk); #1;
        checks++;
        if (app_en !== 1'b1 || app_wdf_wren !== 1'b1) begin
            failures++;
            $display("FAIL stuck_issue got en=%b wren=%b required 1 1", app_en, app_wdf_wren);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({app_en, app_wdf_wren, app_wdf_end, busy, s_axis_tready} !== 5'b00000
            || app_addr !== 27'h0 || app_wdf_data !== 128'h0 || app_wdf_mask !== 16'hFFFF) begin
            failures++;
            $display("FAIL mid_issue_reset got ctrl=%b addr=%0h data=%0h mask=%0h required 00000 0 0 ffff",
                     {app_en, app_wdf_wren, app_wdf_end, busy, s_axis_tready}, app_addr, app_wdf_data, app_wdf_mask);
        end
        rst = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (app_en !== 1'b0 || cmd_count != c0 || s_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset got en=%b cmds=%0d tready=%b required 0 0 1", app_en, cmd_count - c0, s_axis_tready);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_line();
        test_mismatch();
        test_timeout();
        test_backpressure();
        test_overwrite_flush();
        test_back_to_back();
        test_reset_mid_issue();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
